// File: rtl/line_stim_seq.sv
// Line-angle stimulus sequencer: queues {theta, dwell, gap, chk} segments, ramps
// line_theta toward each target in bounded steps, and optionally checks the robot heading.
module line_stim_seq #(
  parameter int THETA_W  = 13,
  parameter int MAX_STEP = 250,
  parameter int DWELL_W  = 24,
  parameter int DEPTH    = 4,
  parameter int TOL      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      seg_vld,
  output logic                      seg_rdy,
  input  logic signed [THETA_W-1:0] seg_theta,
  input  logic [DWELL_W-1:0]        seg_dwell,
  input  logic [DWELL_W-1:0]        seg_gap,
  input  logic                      seg_chk,
  input  logic                      abort,
  input  logic signed [THETA_W-1:0] theta_robot,
  output logic signed [THETA_W-1:0] line_theta,
  output logic                      line_present,
  output logic                      busy,
  output logic                      chk_vld,
  output logic                      chk_pass,
  output logic [7:0]                err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [THETA_W:0]   STEP_LIM  = (THETA_W+1)'(MAX_STEP);
  localparam logic signed [THETA_W:0]   TOL_LIM   = (THETA_W+1)'(TOL);
  localparam logic signed [THETA_W+1:0] THETA_MAX = (THETA_W+2)'((2**(THETA_W-1)) - 1);
  localparam logic signed [THETA_W+1:0] THETA_MIN = (THETA_W+2)'(-(2**(THETA_W-1)));

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_STEP, S_DWELL, S_CHECK} state_t;

  function automatic logic signed [THETA_W:0] clamp_step(input logic signed [THETA_W:0] d);
    if (d > STEP_LIM) return STEP_LIM;
    if (d < -STEP_LIM) return -STEP_LIM;
    return d;
  endfunction

  function automatic logic signed [THETA_W-1:0] sat_add(
    input logic signed [THETA_W-1:0] a,
    input logic signed [THETA_W:0]   d
  );
    logic signed [THETA_W+1:0] s;
    s = (THETA_W+2)'(a) + (THETA_W+2)'(d);
    if (s > THETA_MAX) return THETA_MAX[THETA_W-1:0];
    if (s < THETA_MIN) return THETA_MIN[THETA_W-1:0];
    return s[THETA_W-1:0];
  endfunction

  function automatic logic signed [THETA_W:0] abs_diff(
    input logic signed [THETA_W-1:0] a,
    input logic signed [THETA_W-1:0] b
  );
    logic signed [THETA_W:0] d;
    d = (THETA_W+1)'(a) - (THETA_W+1)'(b);
    return d[THETA_W] ? -d : d;
  endfunction

  // Segment queue
  logic signed [THETA_W-1:0] q_theta [DEPTH];
  logic [DWELL_W-1:0]        q_dwell [DEPTH];
  logic [DWELL_W-1:0]        q_gap   [DEPTH];
  logic [DEPTH-1:0]          q_chk;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic                      push, pop;

  state_t                    state_q, state_d;
  logic signed [THETA_W-1:0] tgt;
  logic [DWELL_W-1:0]        w_dwell;
  logic                      w_chk;
  logic [DWELL_W-1:0]        cnt;
  logic signed [THETA_W:0]   diff, step_amt;
  logic                      at_target, chk_ok;

  assign seg_rdy   = (count != CW'(DEPTH));
  assign push      = seg_vld && seg_rdy && !abort;
  assign pop       = (state_q == S_IDLE) && (count != '0) && !abort;
  assign busy      = (state_q != S_IDLE) || (count != '0);
  assign at_target = (line_theta == tgt);
  assign diff      = (THETA_W+1)'(tgt) - (THETA_W+1)'(line_theta);
  assign step_amt  = clamp_step(diff);
  assign chk_ok    = (abs_diff(theta_robot, line_theta) <= TOL_LIM);

  always_ff @(posedge clk) begin
    if (push) begin
      q_theta[wr_ptr] <= seg_theta;
      q_dwell[wr_ptr] <= seg_dwell;
      q_gap[wr_ptr]   <= seg_gap;
      q_chk[wr_ptr]   <= seg_chk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Working registers of the active segment
  always_ff @(posedge clk) begin
    if (pop) begin
      tgt     <= q_theta[rd_ptr];
      w_dwell <= q_dwell[rd_ptr];
      w_chk   <= q_chk[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = (q_gap[rd_ptr] != '0) ? S_GAP : S_STEP;
      S_GAP:   if (cnt <= DWELL_W'(1)) state_d = S_STEP;
      S_STEP: begin
        if (at_target) state_d = w_chk ? S_CHECK : S_IDLE;
        else           state_d = S_DWELL;
      end
      S_DWELL: if (cnt <= DWELL_W'(1)) state_d = S_STEP;
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Stimulus outputs, shared gap/dwell counter and check results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_theta   <= '0;
      line_present <= 1'b1;
      cnt          <= '0;
      chk_vld      <= 1'b0;
      chk_pass     <= 1'b0;
      err_cnt      <= '0;
    end else begin
      chk_vld <= 1'b0;
      if (abort) begin
        line_present <= 1'b1;
        cnt          <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pop && (q_gap[rd_ptr] != '0)) begin
              cnt          <= q_gap[rd_ptr];
              line_present <= 1'b0;
            end
          end
          S_GAP: begin
            if (cnt <= DWELL_W'(1)) line_present <= 1'b1;
            else                    cnt <= cnt - DWELL_W'(1);
          end
          S_STEP: begin
            if (!at_target) begin
              line_theta <= sat_add(line_theta, step_amt);
              cnt        <= (w_dwell == '0) ? DWELL_W'(1) : w_dwell;
            end
          end
          S_DWELL: begin
            if (cnt > DWELL_W'(1)) cnt <= cnt - DWELL_W'(1);
          end
          S_CHECK: begin
            chk_vld  <= 1'b1;
            chk_pass <= chk_ok;
            if (!chk_ok && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_stim_seq.sv
// Directed bench for line_stim_seq: reset, ramps, gap, tolerance table, queue, abort, reset-in-gap.
module tb_line_stim_seq;

  logic               clk = 1'b0;
  logic               rst_n, seg_vld, seg_chk, abort;
  logic signed [12:0] seg_theta, theta_robot, line_theta;
  logic [23:0]        seg_dwell, seg_gap;
  logic               seg_rdy, line_present, busy, chk_vld, chk_pass;
  logic [7:0]         err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int chg_val[$];
  int chg_cyc[$];
  int vld_cnt, vld_cyc, low_cnt;

  typedef struct {
    int theta;
    int off;
    int exp_pass;
    int exp_err;
  } tol_vec_t;
  tol_vec_t tv [6];

  line_stim_seq dut (
    .clk(clk), .rst_n(rst_n), .seg_vld(seg_vld), .seg_rdy(seg_rdy),
    .seg_theta(seg_theta), .seg_dwell(seg_dwell), .seg_gap(seg_gap), .seg_chk(seg_chk),
    .abort(abort), .theta_robot(theta_robot), .line_theta(line_theta),
    .line_present(line_present), .busy(busy), .chk_vld(chk_vld), .chk_pass(chk_pass),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_seg(input int th, input int dw, input int gp, input int ck);
    seg_theta = 13'(th);
    seg_dwell = 24'(dw);
    seg_gap   = 24'(gp);
    seg_chk   = ck[0];
    seg_vld   = 1'b1;
    @(negedge clk);
    seg_vld   = 1'b0;
  endtask

  task automatic watch(input int n);
    int prev;
    chg_val.delete();
    chg_cyc.delete();
    vld_cnt = 0;
    vld_cyc = -1;
    low_cnt = 0;
    prev = int'(line_theta);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(line_theta) != prev) begin
        chg_val.push_back(int'(line_theta));
        chg_cyc.push_back(cyc);
        prev = int'(line_theta);
      end
      if (chk_vld) begin
        if (vld_cnt == 0) vld_cyc = cyc;
        vld_cnt++;
      end
      if (!line_present) low_cnt++;
    end
  endtask

  function automatic int val_at(input int i);
    return (i < chg_val.size()) ? chg_val[i] : -99999;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < chg_cyc.size()) ? chg_cyc[i] : -99999;
  endfunction

  task automatic wait_idle(input int lim, input string name);
    int k;
    k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_vld(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (chk_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  t0, acc, k, pulses;
    bit  ok;
    int  exp_up[3];
    int  exp_dn[4];

    tv[0] = '{-260,  10, 1, 0};
    tv[1] = '{-260,  11, 0, 1};
    tv[2] = '{-250, -10, 1, 1};
    tv[3] = '{-250, -11, 0, 2};
    tv[4] = '{ 100,   0, 1, 2};
    tv[5] = '{ 100, 400, 0, 3};
    exp_up = '{250, 500, 600};
    exp_dn = '{350, 100, -150, -260};

    rst_n = 1'b0; seg_vld = 1'b0; seg_chk = 1'b0; abort = 1'b0;
    seg_theta = '0; seg_dwell = '0; seg_gap = '0; theta_robot = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_theta", line_theta, 0);
    check("rst_present", line_present, 1);
    check("rst_busy", busy, 0);
    check("rst_chk_vld", chk_vld, 0);
    check("rst_chk_pass", chk_pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy_first", seg_rdy, 1);

    // Gap only: line removed for exactly 40 cycles, angle unchanged
    push_seg(0, 10, 40, 0);
    watch(60);
    check("gap_low_cycles", low_cnt, 40);
    check("gap_theta_changes", chg_val.size(), 0);
    check("gap_chk_vld", vld_cnt, 0);
    check("gap_busy_end", busy, 0);

    // Positive ramp 0 -> 600; each value lasts dwell + the STEP cycle
    theta_robot = 13'(600);
    push_seg(600, 100, 0, 1);
    t0 = cyc;
    watch(400);
    check("up_steps", chg_val.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("up_val%0d", i), val_at(i), exp_up[i]);
    check("up_first_lat", cyc_at(0) - t0, 2);
    check("up_hold1", cyc_at(1) - cyc_at(0), 101);
    check("up_hold2", cyc_at(2) - cyc_at(1), 101);
    check("up_vld_count", vld_cnt, 1);
    check("up_vld_lat", vld_cyc - cyc_at(2), 102);
    check("up_pass", chk_pass, 1);
    check("up_err", err_cnt, 0);

    // Negative ramp 600 -> -260, no check
    push_seg(-260, 50, 0, 0);
    t0 = cyc;
    watch(300);
    check("dn_steps", chg_val.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("dn_val%0d", i), val_at(i), exp_dn[i]);
    check("dn_first_lat", cyc_at(0) - t0, 2);
    check("dn_hold", cyc_at(3) - cyc_at(2), 51);
    check("dn_vld_count", vld_cnt, 0);

    // Tolerance table
    for (int i = 0; i < 6; i++) begin
      theta_robot = 13'(tv[i].theta + tv[i].off);
      push_seg(tv[i].theta, 2, 0, 1);
      wait_vld(400, ok);
      check($sformatf("tol%0d_seen", i), ok, 1);
      check($sformatf("tol%0d_pass", i), chk_pass, tv[i].exp_pass);
      check($sformatf("tol%0d_err", i), err_cnt, tv[i].exp_err);
      check($sformatf("tol%0d_theta", i), line_theta, tv[i].theta);
      @(negedge clk);
      check($sformatf("tol%0d_pulse_end", i), chk_vld, 0);
      check($sformatf("tol%0d_pass_held", i), chk_pass, tv[i].exp_pass);
    end

    // err_cnt saturation under back-to-back failing checks
    theta_robot = 13'(200);
    seg_theta = 13'(100); seg_dwell = '0; seg_gap = '0; seg_chk = 1'b1; seg_vld = 1'b1;
    k = 0;
    while (err_cnt != 8'hFF && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("sat_reach", err_cnt, 255);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (chk_vld) pulses++;
    end
    check("sat_more_fails", int'(pulses >= 3), 1);
    check("sat_hold", err_cnt, 255);
    check("sat_pass", chk_pass, 0);
    seg_vld = 1'b0;
    wait_idle(50, "sat_idle");

    // Queue fill: 4 accepted, 5th waits for the pop after the long dwell
    push_seg(120, 20, 0, 0);
    t0 = cyc;
    @(negedge clk);
    seg_theta = 13'(120); seg_dwell = 24'd1; seg_gap = '0; seg_chk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q_rdy_%0d", i), seg_rdy, 1);
      seg_vld = 1'b1;
      @(negedge clk);
    end
    check("q_full", seg_rdy, 0);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (seg_rdy) begin
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    seg_vld = 1'b0;
    check("q_fifth_after_pop", acc - t0, 25);
    check("q_full_again", seg_rdy, 0);
    wait_idle(100, "q_idle");
    check("q_theta", line_theta, 120);

    // Push and pop on the same edge with 3 queued keeps the count at 3
    push_seg(140, 30, 0, 0);
    t0 = cyc;
    @(negedge clk);
    seg_theta = 13'(140); seg_dwell = 24'd1;
    seg_vld = 1'b1;
    repeat (3) @(negedge clk);
    seg_vld = 1'b0;
    while (cyc < t0 + 33) @(negedge clk);
    check("q2_three", seg_rdy, 1);
    seg_vld = 1'b1;
    @(negedge clk);
    check("q2_pushpop_rdy", seg_rdy, 1);
    @(negedge clk);
    seg_vld = 1'b0;
    check("q2_full", seg_rdy, 0);
    wait_idle(100, "q2_idle");
    check("q2_theta", line_theta, 140);

    // Abort during DWELL with 3 queued and a simultaneous push
    push_seg(160, 30, 0, 0);
    @(negedge clk);
    seg_theta = 13'(300); seg_dwell = 24'd1; seg_chk = 1'b1;
    seg_vld = 1'b1;
    repeat (3) @(negedge clk);
    seg_vld = 1'b0;
    repeat (6) @(negedge clk);
    check("ab_busy_before", busy, 1);
    check("ab_theta_before", line_theta, 160);
    abort = 1'b1; seg_vld = 1'b1; seg_theta = 13'(-500);
    @(negedge clk);
    abort = 1'b0; seg_vld = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_rdy", seg_rdy, 1);
    check("ab_theta", line_theta, 160);
    check("ab_present", line_present, 1);
    check("ab_vld", chk_vld, 0);
    watch(20);
    check("ab_after_changes", chg_val.size(), 0);
    check("ab_after_vld", vld_cnt, 0);
    check("ab_after_busy", busy, 0);

    // Asynchronous reset in the middle of a gap
    push_seg(500, 5, 40, 1);
    repeat (10) @(negedge clk);
    check("rg_gap_low", line_present, 0);
    rst_n = 1'b0;
    #1;
    check("rg_present_async", line_present, 1);
    check("rg_theta_async", line_theta, 0);
    check("rg_busy", busy, 0);
    check("rg_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rg_rdy_first", seg_rdy, 1);
    watch(50);
    check("rg_after_changes", chg_val.size(), 0);
    check("rg_after_vld", vld_cnt, 0);
    check("rg_after_present", low_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
